// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching instruction fetch unit:
// redirect mode encodings and small word helpers.
package fetch_pkg;

   localparam logic REDIRECT_REL = 1'b0;
   localparam logic REDIRECT_ABS = 1'b1;

   // Instruction memory stores each 16-bit word with its bytes swapped.
   function automatic logic [15:0] byte_swap16(input logic [15:0] word);
      return {word[7:0], word[15:8]};
   endfunction

   // A head word with bit 15 set opens a 32-bit (two-word) instruction.
   function automatic logic is_long(input logic [15:0] word);
      return word[15];
   endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Circular word queue holding {address, instruction word} entries.
// Exposes the two oldest entries so a long instruction can be presented
// in one cycle, and can retire one or two entries per cycle.
module fetch_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop1,
   input  logic                     pop2,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head0,
   output logic [15:0]              head1
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [CW-1:0]    pop_n;

   // Each entry loads only when the write pointer selects it.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clock) begin
            if (push && !clear && (wr_ptr_reg == PW'(gi))) begin
               mem_reg[gi] <= push_data;
            end
         end
      end
   endgenerate

   // Pointer and occupancy update; clear wins over push and pop.
   always_comb begin
      pop_n       = pop2 ? CW'(2) : (pop1 ? CW'(1) : CW'(0));
      wr_ptr_next = wr_ptr_reg + PW'(push);
      rd_ptr_next = rd_ptr_reg + pop_n[PW-1:0];
      count_next  = count_reg + CW'(push) - pop_n;
      if (clear) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign count = count_reg;
   assign head0 = mem_reg[rd_ptr_reg];
   assign head1 = mem_reg[rd_ptr_reg + PW'(1)][15:0];

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: keeps up to DEPTH words queued ahead
// of decode, delivers 16/32-bit instructions over valid/ready, and flushes
// all wrong-path state on a relative or absolute redirect.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int                    PC_WIDTH     = 20,
   parameter int                    DEPTH        = 4,
   parameter int                    OFFSET_WIDTH = 9,
   parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   output logic [PC_WIDTH-1:0]      imem_addr,
   output logic                     imem_req,
   input  logic [15:0]              imem_data,
   input  logic                     redirect_valid,
   input  logic                     redirect_mode,
   input  logic [PC_WIDTH-1:0]      redirect_base,
   input  logic [OFFSET_WIDTH-1:0]  redirect_offset,
   input  logic [PC_WIDTH-1:0]      redirect_target,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst_data,
   output logic                     inst_long,
   output logic [PC_WIDTH-1:0]      inst_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = PC_WIDTH + 16;

   logic [PC_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
   logic                pending_reg, pending_next;
   logic [PC_WIDTH-1:0] pending_addr_reg, pending_addr_next;

   logic [CW-1:0]       count;
   logic [EW-1:0]       head0;
   logic [15:0]         head1_word;
   logic [15:0]         head0_word;
   logic [PC_WIDTH-1:0] head0_pc;
   logic                head_present;
   logic                head_long;
   logic                head_complete;
   logic                accept;
   logic                push;
   logic [CW:0]         occupancy;
   logic [PC_WIDTH-1:0] offset_ext;
   logic [PC_WIDTH-1:0] redirect_pc;

   // Relative redirects add the sign-extended offset; wrap is implicit.
   assign offset_ext  = PC_WIDTH'($signed(redirect_offset));
   assign redirect_pc = (redirect_mode == REDIRECT_ABS) ? redirect_target
                                                        : redirect_base + offset_ext;

   // The in-flight word counts against capacity so a response always has room.
   assign occupancy = {1'b0, count} + (CW + 1)'(pending_reg);
   assign imem_req  = enable & ~reset & ~redirect_valid & (occupancy < (CW + 1)'(DEPTH));
   assign imem_addr = fetch_pc_reg;

   // A response lands the cycle after its request unless a redirect kills it.
   assign push = pending_reg & ~redirect_valid & ~reset;

   assign head0_word    = head0[15:0];
   assign head0_pc      = head0[EW-1:16];
   assign head_present  = (count != '0);
   assign head_long     = is_long(head0_word);
   assign head_complete = head_present & (~head_long | (count >= CW'(2)));

   assign inst_valid = head_complete;
   assign inst_long  = head_present & head_long;
   assign inst_data  = head_present ? {head0_word, (head_long && head_complete) ? head1_word : 16'h0000}
                                    : 32'h0;
   assign inst_pc    = head_present ? head0_pc : fetch_pc_reg;

   assign accept = head_complete & inst_ready & ~redirect_valid;

   fetch_word_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({pending_addr_reg, byte_swap16(imem_data)}),
      .pop1      (accept & ~head_long),
      .pop2      (accept & head_long),
      .clear     (redirect_valid),
      .count     (count),
      .head0     (head0),
      .head1     (head1_word)
   );

   // Next fetch address and in-flight tracking; redirect overrides all.
   always_comb begin
      fetch_pc_next     = fetch_pc_reg;
      pending_next      = imem_req;
      pending_addr_next = pending_addr_reg;
      if (redirect_valid) begin
         fetch_pc_next = redirect_pc;
         pending_next  = 1'b0;
      end else if (imem_req) begin
         fetch_pc_next     = fetch_pc_reg + PC_WIDTH'(1);
         pending_addr_next = fetch_pc_reg;
      end
   end

   // Fetch PC and in-flight request registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_reg     <= RESET_PC;
         pending_reg      <= 1'b0;
         pending_addr_reg <= RESET_PC;
      end else begin
         fetch_pc_reg     <= fetch_pc_next;
         pending_reg      <= pending_next;
         pending_addr_reg <= pending_addr_next;
      end
   end

endmodule
